// File: rtl/slv_read_responder_if.sv
// AR/R channel bundle between a read master (or dispatcher) and slv_read_responder.
interface slv_read_responder_if #(
    parameter int DATA_WIDTH        = 32,
    parameter int ADDR_WIDTH        = 32,
    parameter int TRANS_MST_ID_W    = 5,
    parameter int TRANS_BURST_W     = 2,
    parameter int TRANS_DATA_LEN_W  = 3,
    parameter int TRANS_DATA_SIZE_W = 3
);
    logic [TRANS_MST_ID_W-1:0]    s_ARID;
    logic [ADDR_WIDTH-1:0]        s_ARADDR;
    logic [TRANS_BURST_W-1:0]     s_ARBURST;
    logic [TRANS_DATA_LEN_W-1:0]  s_ARLEN;
    logic [TRANS_DATA_SIZE_W-1:0] s_ARSIZE;
    logic                         s_ARVALID;
    logic                         s_ARREADY;
    logic [TRANS_MST_ID_W-1:0]    s_RID;
    logic [DATA_WIDTH-1:0]        s_RDATA;
    logic                         s_RLAST;
    logic                         s_RVALID;
    logic                         s_RREADY;

    modport master (
        output s_ARID, s_ARADDR, s_ARBURST, s_ARLEN, s_ARSIZE, s_ARVALID, s_RREADY,
        input  s_ARREADY, s_RID, s_RDATA, s_RLAST, s_RVALID
    );

    modport slave (
        input  s_ARID, s_ARADDR, s_ARBURST, s_ARLEN, s_ARSIZE, s_ARVALID, s_RREADY,
        output s_ARREADY, s_RID, s_RDATA, s_RLAST, s_RVALID
    );
endinterface

// File: rtl/slv_read_responder.sv
// AXI4-style read slave: queues AR requests, walks FIXED/INCR/WRAP bursts against a
// 1-cycle synchronous memory and returns R beats in order through a 2-entry skid FIFO.
//
// state    | meaning
// ST_IDLE  | no working burst; load queue head when one is present
// ST_ISSUE | issuing memory reads for the working burst, one per cycle with credit
module slv_read_responder #(
    parameter int DATA_WIDTH        = 32,
    parameter int ADDR_WIDTH        = 32,
    parameter int TRANS_MST_ID_W    = 5,
    parameter int TRANS_BURST_W     = 2,
    parameter int TRANS_DATA_LEN_W  = 3,
    parameter int TRANS_DATA_SIZE_W = 3,
    parameter int OUTSTANDING_AMT   = 4
) (
    input  logic                  ACLK_i,
    input  logic                  ARESET_i,
    slv_read_responder_if.slave   s_if,
    output logic                  mem_rd_en_o,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_rd_data_i
);
    localparam int BPW      = DATA_WIDTH / 8;
    localparam int LOG2_BPW = $clog2(BPW);
    localparam int QP_W     = $clog2(OUTSTANDING_AMT);
    localparam logic [TRANS_BURST_W-1:0] BURST_FIXED = TRANS_BURST_W'(0);
    localparam logic [TRANS_BURST_W-1:0] BURST_INCR  = TRANS_BURST_W'(1);
    localparam logic [TRANS_BURST_W-1:0] BURST_WRAP  = TRANS_BURST_W'(2);

    typedef enum logic {ST_IDLE, ST_ISSUE} state_t;

    state_t r_state, w_state_nxt;

    logic [TRANS_MST_ID_W-1:0]    r_q_id    [OUTSTANDING_AMT];
    logic [ADDR_WIDTH-1:0]        r_q_addr  [OUTSTANDING_AMT];
    logic [TRANS_BURST_W-1:0]     r_q_burst [OUTSTANDING_AMT];
    logic [TRANS_DATA_LEN_W-1:0]  r_q_len   [OUTSTANDING_AMT];
    logic [TRANS_DATA_SIZE_W-1:0] r_q_size  [OUTSTANDING_AMT];
    logic [QP_W-1:0]              r_q_wp, r_q_rp;
    logic [QP_W:0]                r_q_cnt;
    logic                         w_q_full, w_q_empty, w_push;

    logic [ADDR_WIDTH-1:0]        w_h_addr, w_h_sz, w_h_beats, w_h_wmask;
    logic [TRANS_DATA_SIZE_W-1:0] w_h_size;
    logic [TRANS_BURST_W-1:0]     w_h_burst;
    logic                         w_h_wrap_ok;

    logic [ADDR_WIDTH-1:0]        r_addr, r_sz, r_wmask;
    logic [TRANS_MST_ID_W-1:0]    r_id;
    logic [TRANS_BURST_W-1:0]     r_burst;
    logic [TRANS_DATA_LEN_W-1:0]  r_rem;
    logic [ADDR_WIDTH-1:0]        w_incr_addr, w_wrap_base, w_wrap_addr, w_next_addr;

    logic                         r_if_vld, r_if_last;
    logic [TRANS_MST_ID_W-1:0]    r_if_id;
    logic [DATA_WIDTH-1:0]        r_sk_data [2];
    logic [TRANS_MST_ID_W-1:0]    r_sk_id   [2];
    logic                         r_sk_last [2];
    logic                         r_sk_wp, r_sk_rp;
    logic [1:0]                   r_sk_cnt;
    logic                         w_sk_pop, w_credit, w_issue, w_load;

    assign w_q_full          = (r_q_cnt == (QP_W+1)'(OUTSTANDING_AMT));
    assign w_q_empty         = (r_q_cnt == '0);
    assign s_if.s_ARREADY    = !w_q_full && !ARESET_i;
    assign w_push            = s_if.s_ARVALID && s_if.s_ARREADY;

    always_ff @(posedge ACLK_i) begin
        if (w_push) begin
            r_q_id[r_q_wp]    <= s_if.s_ARID;
            r_q_addr[r_q_wp]  <= s_if.s_ARADDR;
            r_q_burst[r_q_wp] <= s_if.s_ARBURST;
            r_q_len[r_q_wp]   <= s_if.s_ARLEN;
            r_q_size[r_q_wp]  <= s_if.s_ARSIZE;
        end
    end

    always_ff @(posedge ACLK_i) begin
        if (ARESET_i) begin
            r_q_wp  <= '0;
            r_q_rp  <= '0;
            r_q_cnt <= '0;
        end else begin
            if (w_push) r_q_wp <= r_q_wp + 1'b1;
            if (w_load) r_q_rp <= r_q_rp + 1'b1;
            case ({w_push, w_load})
                2'b10:   r_q_cnt <= r_q_cnt + 1'b1;
                2'b01:   r_q_cnt <= r_q_cnt - 1'b1;
                default: r_q_cnt <= r_q_cnt;
            endcase
        end
    end

    // Head decode: clamp SIZE, and downgrade illegal WRAP (bad length or unaligned) to INCR.
    always_comb begin
        w_h_addr  = r_q_addr[r_q_rp];
        w_h_size  = (r_q_size[r_q_rp] > TRANS_DATA_SIZE_W'(LOG2_BPW)) ?
                    TRANS_DATA_SIZE_W'(LOG2_BPW) : r_q_size[r_q_rp];
        w_h_sz    = ADDR_WIDTH'(1) << w_h_size;
        w_h_beats = ADDR_WIDTH'(r_q_len[r_q_rp]) + ADDR_WIDTH'(1);
        w_h_wmask = (w_h_sz * w_h_beats) - ADDR_WIDTH'(1);
        w_h_wrap_ok = (r_q_burst[r_q_rp] == BURST_WRAP) &&
                      ((w_h_beats == ADDR_WIDTH'(2)) || (w_h_beats == ADDR_WIDTH'(4)) ||
                       (w_h_beats == ADDR_WIDTH'(8))) &&
                      ((w_h_addr & (w_h_sz - ADDR_WIDTH'(1))) == '0);
        if (r_q_burst[r_q_rp] == BURST_FIXED) w_h_burst = BURST_FIXED;
        else if (w_h_wrap_ok)                 w_h_burst = BURST_WRAP;
        else                                  w_h_burst = BURST_INCR;
    end

    always_comb begin
        w_incr_addr = (r_addr & ~(r_sz - ADDR_WIDTH'(1))) + r_sz;
        w_wrap_base = r_addr & ~r_wmask;
        w_wrap_addr = w_wrap_base + ((r_addr + r_sz - w_wrap_base) & r_wmask);
        case (r_burst)
            BURST_FIXED: w_next_addr = r_addr;
            BURST_WRAP:  w_next_addr = w_wrap_addr;
            default:     w_next_addr = w_incr_addr;
        endcase
    end

    always_ff @(posedge ACLK_i) begin
        if (ARESET_i) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (!w_q_empty) w_state_nxt = ST_ISSUE;
            ST_ISSUE: if (w_issue && (r_rem == '0) && !w_load) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Credit counts the beat arriving from memory plus skid entries left after this cycle's pop.
    always_comb begin
        w_credit      = ((2'(r_if_vld) + r_sk_cnt - 2'(w_sk_pop)) < 2'd2);
        w_issue       = (r_state == ST_ISSUE) && w_credit;
        w_load        = !w_q_empty && ((r_state == ST_IDLE) || (w_issue && (r_rem == '0)));
        mem_rd_en_o   = w_issue;
        mem_rd_addr_o = r_addr & ~ADDR_WIDTH'(BPW - 1);
    end

    always_ff @(posedge ACLK_i) begin
        if (ARESET_i) begin
            r_addr  <= '0;
            r_sz    <= '0;
            r_wmask <= '0;
            r_id    <= '0;
            r_burst <= '0;
            r_rem   <= '0;
        end else if (w_load) begin
            r_addr  <= w_h_addr;
            r_sz    <= w_h_sz;
            r_wmask <= w_h_wmask;
            r_id    <= r_q_id[r_q_rp];
            r_burst <= w_h_burst;
            r_rem   <= r_q_len[r_q_rp];
        end else if (w_issue) begin
            r_addr  <= w_next_addr;
            r_rem   <= r_rem - 1'b1;
        end
    end

    assign w_sk_pop = (r_sk_cnt != 2'd0) && s_if.s_RREADY;

    always_ff @(posedge ACLK_i) begin
        if (ARESET_i) begin
            r_if_vld  <= 1'b0;
            r_if_id   <= '0;
            r_if_last <= 1'b0;
            r_sk_wp   <= 1'b0;
            r_sk_rp   <= 1'b0;
            r_sk_cnt  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_sk_data[i] <= '0;
                r_sk_id[i]   <= '0;
                r_sk_last[i] <= 1'b0;
            end
        end else begin
            r_if_vld  <= w_issue;
            r_if_id   <= r_id;
            r_if_last <= (r_rem == '0);
            if (r_if_vld) begin
                r_sk_data[r_sk_wp] <= mem_rd_data_i;
                r_sk_id[r_sk_wp]   <= r_if_id;
                r_sk_last[r_sk_wp] <= r_if_last;
                r_sk_wp            <= ~r_sk_wp;
            end
            if (w_sk_pop) r_sk_rp <= ~r_sk_rp;
            case ({r_if_vld, w_sk_pop})
                2'b10:   r_sk_cnt <= r_sk_cnt + 2'd1;
                2'b01:   r_sk_cnt <= r_sk_cnt - 2'd1;
                default: r_sk_cnt <= r_sk_cnt;
            endcase
        end
    end

    assign s_if.s_RVALID = (r_sk_cnt != 2'd0);
    assign s_if.s_RID    = r_sk_id[r_sk_rp];
    assign s_if.s_RDATA  = r_sk_data[r_sk_rp];
    assign s_if.s_RLAST  = r_sk_last[r_sk_rp] && (r_sk_cnt != 2'd0);

endmodule

// File: tb/tb_slv_read_responder.sv
// Scoreboard bench for slv_read_responder: burst reference model feeds expected
// memory addresses and R beats; a negedge monitor compares what the DUT presents.
module tb_slv_read_responder;
    localparam int DW = 32, AW = 32, IDW = 5, BW = 2, LW = 3, SW = 3, OUT = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data = '0;

    always #5 clk = ~clk;

    slv_read_responder_if #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TRANS_MST_ID_W(IDW), .TRANS_BURST_W(BW),
        .TRANS_DATA_LEN_W(LW), .TRANS_DATA_SIZE_W(SW)
    ) bus ();

    slv_read_responder #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TRANS_MST_ID_W(IDW), .TRANS_BURST_W(BW),
        .TRANS_DATA_LEN_W(LW), .TRANS_DATA_SIZE_W(SW), .OUTSTANDING_AMT(OUT)
    ) dut (
        .ACLK_i        (clk),
        .ARESET_i      (rst),
        .s_if          (bus.slave),
        .mem_rd_en_o   (mem_rd_en),
        .mem_rd_addr_o (mem_rd_addr),
        .mem_rd_data_i (mem_rd_data)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ {a[15:0], a[31:16]} ^ 32'hA5C3_0F1E;
    endfunction

    always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem_word(mem_rd_addr);

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [DW-1:0]  data;
        logic           last;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] addr_q[$];
    int          tests = 0, fails = 0;
    int          r_beats = 0, outstanding = 0, max_out = 0;
    bit          rr_rand = 0;
    beat_t       mb;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: address of beat i computed directly from the burst rules.
    task automatic expect_burst(input logic [IDW-1:0] id, input logic [31:0] addr,
                                input logic [1:0] burst, input logic [2:0] len,
                                input logic [2:0] size);
        int          s, beats;
        logic [31:0] sz, w, base, a;
        bit          wrap;
        beat_t       b;
        s     = (size > 3'd2) ? 2 : int'(size);
        sz    = 32'd1 << s;
        beats = int'(len) + 1;
        wrap  = (burst == 2'd2) && (beats == 2 || beats == 4 || beats == 8) && (addr % sz == 0);
        w     = sz * 32'(beats);
        base  = addr - (addr % w);
        for (int i = 0; i < beats; i++) begin
            if (burst == 2'd0)  a = addr;
            else if (wrap)      a = base + ((addr - base + 32'(i) * sz) % w);
            else if (i == 0)    a = addr;
            else                a = addr - (addr % sz) + 32'(i) * sz;
            addr_q.push_back(a & ~32'h3);
            b.id   = id;
            b.data = mem_word(a & ~32'h3);
            b.last = (i == beats - 1);
            exp_q.push_back(b);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            outstanding = 0;
        end else begin
            if (bus.s_ARVALID && bus.s_ARREADY)
                expect_burst(bus.s_ARID, bus.s_ARADDR, bus.s_ARBURST, bus.s_ARLEN, bus.s_ARSIZE);
            if (mem_rd_en) begin
                if (addr_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL mem_unexpected: read at %0h with no expected address", mem_rd_addr);
                end else check("mem_addr", 64'(mem_rd_addr), 64'(addr_q.pop_front()));
            end
            if (bus.s_RVALID && bus.s_RREADY) begin
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL r_unexpected: beat id %0h with empty scoreboard", bus.s_RID);
                end else begin
                    mb = exp_q.pop_front();
                    check("rid",   64'(bus.s_RID),   64'(mb.id));
                    check("rdata", 64'(bus.s_RDATA), 64'(mb.data));
                    check("rlast", 64'(bus.s_RLAST), 64'(mb.last));
                end
                r_beats++;
            end
            outstanding = outstanding + int'(mem_rd_en) - int'(bus.s_RVALID && bus.s_RREADY);
            if (outstanding > max_out) max_out = outstanding;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rr_rand) bus.s_RREADY = 1'($urandom_range(0, 1));
    endtask

    task automatic ar_drive(input logic [IDW-1:0] id, input logic [31:0] addr,
                            input logic [1:0] burst, input logic [2:0] len, input logic [2:0] size);
        bus.s_ARID    = id;
        bus.s_ARADDR  = addr;
        bus.s_ARBURST = burst;
        bus.s_ARLEN   = len;
        bus.s_ARSIZE  = size;
        bus.s_ARVALID = 1'b1;
    endtask

    task automatic ar_wait();
        int n = 0;
        while (n < 300) begin
            @(negedge clk);
            if (bus.s_ARREADY) break;
            n++;
            tick();
        end
        check("ar_accept_timeout", 64'(n >= 300), 64'(0));
        tick();
        bus.s_ARVALID = 1'b0;
    endtask

    task automatic send_ar(input logic [IDW-1:0] id, input logic [31:0] addr,
                           input logic [1:0] burst, input logic [2:0] len, input logic [2:0] size);
        ar_drive(id, addr, burst, len, size);
        ar_wait();
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || bus.s_RVALID) && n < 2000) begin
            tick();
            n++;
        end
        check("drain_timeout", 64'(n >= 2000), 64'(0));
        check("addr_q_empty", 64'(addr_q.size()), 64'(0));
    endtask

    initial begin
        int          lat, run, hi, base;
        logic [31:0] ra;
        logic [2:0]  rs;
        bus.s_ARVALID = 1'b0; bus.s_ARID = '0; bus.s_ARADDR = '0; bus.s_ARBURST = '0;
        bus.s_ARLEN = '0; bus.s_ARSIZE = '0; bus.s_RREADY = 1'b0;
        repeat (3) tick();
        check("rst_arready", 64'(bus.s_ARREADY), 64'(0));
        check("rst_rvalid",  64'(bus.s_RVALID),  64'(0));
        check("rst_rlast",   64'(bus.s_RLAST),   64'(0));
        check("rst_rid",     64'(bus.s_RID),     64'(0));
        check("rst_rdata",   64'(bus.s_RDATA),   64'(0));
        check("rst_mem_en",  64'(mem_rd_en),     64'(0));
        check("rst_mem_addr",64'(mem_rd_addr),   64'(0));
        rst = 1'b0;
        tick();

        // single INCR: latency and back-to-back beats
        bus.s_RREADY = 1'b1;
        send_ar(5'd5, 32'h100, 2'd1, 3'd3, 3'd2);
        lat = 0;
        while (lat < 20) begin
            tick();
            lat++;
            if (bus.s_RVALID) break;
        end
        check("first_rvalid_latency", 64'(lat), 64'(3));
        run = 0;
        repeat (3) begin
            tick();
            if (bus.s_RVALID) run++;
        end
        check("contiguous_beats", 64'(run), 64'(3));
        drain();

        send_ar(5'd2, 32'h38, 2'd2, 3'd3, 3'd2);
        send_ar(5'd3, 32'h20, 2'd0, 3'd2, 3'd2);
        send_ar(5'd4, 32'h103, 2'd1, 3'd1, 3'd2);
        drain();

        // fill the queue while R is stalled
        bus.s_RREADY = 1'b0;
        for (int i = 1; i <= 5; i++) send_ar(IDW'(i), 32'(i) * 32'h200, 2'd1, 3'd3, 3'd2);
        check("fill_arready_low", 64'(bus.s_ARREADY), 64'(0));
        ar_drive(5'd6, 32'hC00, 2'd1, 3'd3, 3'd2);
        hi = 0;
        repeat (6) begin
            tick();
            if (bus.s_ARREADY) hi++;
        end
        check("fill_arready_held", 64'(hi), 64'(0));
        check("hold_rvalid", 64'(bus.s_RVALID), 64'(1));
        check("hold_rid",    64'(bus.s_RID),    64'(1));
        check("hold_rdata",  64'(bus.s_RDATA),  64'(mem_word(32'h200)));
        check("hold_rlast",  64'(bus.s_RLAST),  64'(0));
        bus.s_RREADY = 1'b1;
        ar_wait();
        drain();

        // LEN=7 INCR with random backpressure
        rr_rand = 1;
        base = r_beats;
        send_ar(5'd9, 32'h1000, 2'd1, 3'd7, 3'd2);
        drain();
        check("len7_beats", 64'(r_beats - base), 64'(8));

        // random mix of bursts
        for (int k = 0; k < 30; k++) begin
            rs = 3'($urandom_range(0, 3));
            ra = $urandom & 32'h0000_FFFF;
            if ($urandom_range(0, 1) == 1) ra = ra & ~((32'd1 << ((rs > 3'd2) ? 2 : rs)) - 32'd1);
            send_ar(IDW'($urandom), ra, 2'($urandom_range(0, 2)), 3'($urandom_range(0, 7)), rs);
            repeat ($urandom_range(0, 2)) tick();
        end
        drain();
        rr_rand = 0;
        bus.s_RREADY = 1'b1;

        // reset mid-burst
        base = r_beats;
        ar_drive(5'd7, 32'h400, 2'd1, 3'd7, 3'd2);
        ar_wait();
        run = 0;
        while (r_beats < base + 2 && run < 100) begin
            tick();
            run++;
        end
        check("pre_reset_beats", 64'(r_beats - base), 64'(2));
        rst = 1'b1;
        exp_q.delete();
        addr_q.delete();
        tick();
        check("reset_rvalid",  64'(bus.s_RVALID),  64'(0));
        check("reset_arready", 64'(bus.s_ARREADY), 64'(0));
        check("reset_mem_en",  64'(mem_rd_en),     64'(0));
        tick();
        rst = 1'b0;
        tick();
        base = r_beats;
        send_ar(5'd11, 32'h500, 2'd1, 3'd0, 3'd2);
        drain();
        check("post_reset_beats", 64'(r_beats - base), 64'(1));

        check("credit_max_le_2", 64'(max_out <= 2), 64'(1));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
